pmod_ad1: RTL and testbench

PMOD_AD1 -- requirements
Module: pmod_ad1

---
 rtl/pmod_ad1.sv | 198 +++++++++++++++++++
 tb/tb_pmod_ad1.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_ad1.sv
// Dual AD7476A (PmodAD1) serial capture controller.
// Runs one CS frame per START_i, shifting 16 bits from both converters at once.
//
// Ports:
//   CLK_i            system clock, rising edge
//   RST_i            synchronous active-high reset
//   START_i          conversion request, honoured only while idle
//   BUSY_o           high from frame start until the quiet gap ends
//   AD7476A_CS_o     shared active-low chip select
//   AD7476A_SCLK_o   shared serial clock, idles high
//   AD7476A_SDATA0_i serial data from channel 0
//   AD7476A_SDATA1_i serial data from channel 1
//   ADC_DATA0_o      last completed channel-0 sample
//   ADC_DATA1_o      last completed channel-1 sample
//   ADC_VALID_o      one-cycle pulse when the data outputs update
//   ADC_ERR_o        a leading bit of either channel was 1 in the last frame

module pmod_ad1 #(
    parameter int unsigned CLK_DIV      = 3,
    parameter int unsigned QUIET_CYCLES = 5
) (
    input  logic        CLK_i,
    input  logic        RST_i,
    input  logic        START_i,
    output logic        BUSY_o,
    output logic        AD7476A_CS_o,
    output logic        AD7476A_SCLK_o,
    input  logic        AD7476A_SDATA0_i,
    input  logic        AD7476A_SDATA1_i,
    output logic [11:0] ADC_DATA0_o,
    output logic [11:0] ADC_DATA1_o,
    output logic        ADC_VALID_o,
    output logic        ADC_ERR_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_QUIET
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  quiet_q, quiet_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [15:0] sh0_q, sh0_d;
    logic [15:0] sh1_q, sh1_d;
    logic [11:0] data0_q, data0_d;
    logic [11:0] data1_q, data1_d;

    logic        phase_end;

    assign phase_end = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        quiet_d = quiet_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        err_d   = err_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        data0_d = data0_q;
        data1_d = data1_q;

        unique case (state_q)
            S_IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                busy_d = 1'b0;
                if (START_i) begin
                    state_d = S_SETUP;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    sh0_d   = '0;
                    sh1_d   = '0;
                end
            end

            S_SETUP: begin
                if (phase_end) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            // Data is captured on the edge that drives SCLK high; the
            // 16th rising edge starts the final high phase, which is HOLD.
            S_SHIFT: begin
                if (phase_end) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        sh0_d = {sh0_q[14:0], AD7476A_SDATA0_i};
                        sh1_d = {sh1_q[14:0], AD7476A_SDATA1_i};
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd15) begin
                            state_d = S_HOLD;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            S_HOLD: begin
                if (phase_end) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    valid_d = 1'b1;
                    data0_d = sh0_q[11:0];
                    data1_d = sh1_q[11:0];
                    err_d   = (|sh0_q[15:12]) | (|sh1_q[15:12]);
                    quiet_d = '0;
                    state_d = S_QUIET;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            S_QUIET: begin
                if (quiet_q == QUIET_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    quiet_d = quiet_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            quiet_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            quiet_q <= quiet_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign BUSY_o         = busy_q;
    assign AD7476A_CS_o   = cs_q;
    assign AD7476A_SCLK_o = sclk_q;
    assign ADC_DATA0_o    = data0_q;
    assign ADC_DATA1_o    = data1_q;
    assign ADC_VALID_o    = valid_q;
    assign ADC_ERR_o      = err_q;

endmodule

// File: tb/tb_pmod_ad1.sv
// Directed bench for pmod_ad1 with a behavioural dual AD7476A model.
// Default parameters: CLK_DIV=3, QUIET_CYCLES=5.

module tb_pmod_ad1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        cs;
    logic        sclk;
    logic        sd0;
    logic        sd1;
    logic [11:0] d0;
    logic [11:0] d1;
    logic        valid;
    logic        err;

    logic [15:0] m0;
    logic [15:0] m1;
    logic [15:0] s0;
    logic [15:0] s1;

    int n_checks;
    int n_fail;

    pmod_ad1 dut (
        .CLK_i           (clk),
        .RST_i           (rst),
        .START_i         (start),
        .BUSY_o          (busy),
        .AD7476A_CS_o    (cs),
        .AD7476A_SCLK_o  (sclk),
        .AD7476A_SDATA0_i(sd0),
        .AD7476A_SDATA1_i(sd1),
        .ADC_DATA0_o     (d0),
        .ADC_DATA1_o     (d1),
        .ADC_VALID_o     (valid),
        .ADC_ERR_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Converter model: word latched at CS fall, one bit out per SCLK fall.
    always @(negedge cs or negedge sclk) begin
        if (sclk) begin
            s0 <= m0;
            s1 <= m1;
        end else if (!cs) begin
            sd0 <= s0[15];
            sd1 <= s1[15];
            s0  <= {s0[14:0], 1'b0};
            s1  <= {s1[14:0], 1'b0};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40; n++) begin
            if (!busy) break;
            step();
        end
    endtask

    // Pulses START for one cycle and returns the cycle of the VALID pulse.
    task automatic run_conv(input logic [15:0] w0, input logic [15:0] w1,
                            output int lat);
        m0    = w0;
        m1    = w1;
        start = 1'b1;
        lat   = -1;
        for (int n = 1; n <= 300; n++) begin
            step();
            start = 1'b0;
            if (valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) step();
        n_checks++;
        if (cs !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cs: got %b expected 1", cs);
        end
        n_checks++;
        if (sclk !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sclk: got %b expected 1", sclk);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", valid);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", err);
        end
        n_checks++;
        if (d0 !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_d0: got %h expected 000", d0);
        end
        n_checks++;
        if (d1 !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_d1: got %h expected 000", d1);
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || cs !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_over_start: got busy=%b cs=%b expected 0/1",
                     busy, cs);
        end
    endtask

    task automatic test_basic();
        int lat;
        m0    = 16'h0ABC;
        m1    = 16'h0555;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || cs !== 1'b0) begin
            n_fail++;
            $display("FAIL start_accept: got busy=%b cs=%b expected 1/0",
                     busy, cs);
        end
        lat = -1;
        for (int n = 2; n <= 300; n++) begin
            step();
            if (valid) begin
                lat = n;
                break;
            end
        end
        n_checks++;
        if (lat != 100) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 100", lat);
        end
        n_checks++;
        if (d0 !== 12'hABC) begin
            n_fail++;
            $display("FAIL basic_d0: got %h expected abc", d0);
        end
        n_checks++;
        if (d1 !== 12'h555) begin
            n_fail++;
            $display("FAIL basic_d1: got %h expected 555", d1);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_err: got %b expected 0", err);
        end
        step();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse_width: got %b expected 0", valid);
        end
        m0 = 16'h0FFF;
        repeat (10) step();
        n_checks++;
        if (d0 !== 12'hABC || d1 !== 12'h555) begin
            n_fail++;
            $display("FAIL data_hold: got %h/%h expected abc/555", d0, d1);
        end
        wait_idle();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_release: got %b expected 0", busy);
        end
    endtask

    task automatic test_err();
        int lat;
        run_conv(16'h0ABC, 16'h8123, lat);
        n_checks++;
        if (lat != 100) begin
            n_fail++;
            $display("FAIL err_latency: got %0d expected 100", lat);
        end
        n_checks++;
        if (d1 !== 12'h123) begin
            n_fail++;
            $display("FAIL err_d1: got %h expected 123", d1);
        end
        n_checks++;
        if (d0 !== 12'hABC) begin
            n_fail++;
            $display("FAIL err_d0: got %h expected abc", d0);
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_flag: got %b expected 1", err);
        end
        wait_idle();
    endtask

    task automatic test_waveform();
        int cs_low, falls, bad_hi, bad_lo, hi_viol, run;
        logic s, c, ps, pc;
        cs_low  = 0;
        falls   = 0;
        bad_hi  = 0;
        bad_lo  = 0;
        hi_viol = 0;
        run     = 0;
        ps      = 1'b1;
        pc      = 1'b1;
        m0      = 16'h0123;
        m1      = 16'h0456;
        start   = 1'b1;
        for (int i = 0; i < 130; i++) begin
            step();
            start = 1'b0;
            s = sclk;
            c = cs;
            if (!c) cs_low++;
            if (c && !s) hi_viol++;
            if (!pc) begin
                if (s == ps && !c) begin
                    run++;
                end else begin
                    if (ps) begin
                        if (run != 3) bad_hi++;
                    end else begin
                        if (run != 3) bad_lo++;
                    end
                    if (ps && !s) falls++;
                    run = 1;
                end
            end else if (!c) begin
                run = 1;
            end
            ps = s;
            pc = c;
        end
        n_checks++;
        if (cs_low != 99) begin
            n_fail++;
            $display("FAIL wave_cs_low: got %0d expected 99", cs_low);
        end
        n_checks++;
        if (falls != 16) begin
            n_fail++;
            $display("FAIL wave_falls: got %0d expected 16", falls);
        end
        n_checks++;
        if (bad_hi != 0) begin
            n_fail++;
            $display("FAIL wave_high_phase: got %0d bad expected 0", bad_hi);
        end
        n_checks++;
        if (bad_lo != 0) begin
            n_fail++;
            $display("FAIL wave_low_phase: got %0d bad expected 0", bad_lo);
        end
        n_checks++;
        if (hi_viol != 0) begin
            n_fail++;
            $display("FAIL wave_idle_sclk: got %0d expected 0", hi_viol);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int t[3];
        int k, gap, extra;
        k     = 0;
        gap   = 0;
        extra = 0;
        t[0]  = -1;
        t[1]  = -1;
        t[2]  = -1;
        m0    = 16'h0321;
        m1    = 16'h0654;
        start = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            step();
            if (valid) begin
                if (k < 3) begin
                    t[k] = n;
                    k++;
                    if (k == 3) start = 1'b0;
                end else begin
                    extra++;
                end
            end
            if (k == 1 && cs) gap++;
        end
        start = 1'b0;
        n_checks++;
        if (t[0] != 100) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d expected 100", t[0]);
        end
        n_checks++;
        if (t[1] - t[0] != 105) begin
            n_fail++;
            $display("FAIL b2b_space1: got %0d expected 105", t[1] - t[0]);
        end
        n_checks++;
        if (t[2] - t[1] != 105) begin
            n_fail++;
            $display("FAIL b2b_space2: got %0d expected 105", t[2] - t[1]);
        end
        n_checks++;
        if (gap != 6) begin
            n_fail++;
            $display("FAIL b2b_cs_gap: got %0d expected 6", gap);
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL b2b_extra: got %0d expected 0", extra);
        end
        wait_idle();
    endtask

    task automatic test_ignore();
        int cnt, first;
        cnt   = 0;
        first = -1;
        m0    = 16'h0111;
        m1    = 16'h0222;
        start = 1'b1;
        for (int n = 1; n <= 320; n++) begin
            step();
            start = (n == 50 || n == 99 || n == 102);
            if (valid) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        start = 1'b0;
        n_checks++;
        if (cnt != 1) begin
            n_fail++;
            $display("FAIL ignore_count: got %0d expected 1", cnt);
        end
        n_checks++;
        if (first != 100) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected 100", first);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int rises, vcnt, lat;
        logic ps;
        rises = 0;
        vcnt  = 0;
        ps    = 1'b1;
        m0    = 16'h0ABC;
        m1    = 16'h0555;
        start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            step();
            start = 1'b0;
            if (valid) vcnt++;
            if (!ps && sclk) rises++;
            ps = sclk;
            if (rises == 8) break;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (rises != 8) begin
            n_fail++;
            $display("FAIL mid_reach_edge8: got %0d expected 8", rises);
        end
        n_checks++;
        if (cs !== 1'b1 || sclk !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_cs_sclk: got %b/%b expected 1/1", cs, sclk);
        end
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_flags: got busy=%b valid=%b err=%b expected 0",
                     busy, valid, err);
        end
        n_checks++;
        if (d0 !== 12'h000 || d1 !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_data: got %h/%h expected 000/000", d0, d1);
        end
        for (int n = 0; n < 150; n++) begin
            step();
            if (valid) vcnt++;
        end
        n_checks++;
        if (vcnt != 0) begin
            n_fail++;
            $display("FAIL mid_no_valid: got %0d expected 0", vcnt);
        end
        run_conv(16'h0321, 16'h0456, lat);
        n_checks++;
        if (lat != 100 || d0 !== 12'h321 || d1 !== 12'h456) begin
            n_fail++;
            $display("FAIL mid_restart: got lat=%0d %h/%h expected 100 321/456",
                     lat, d0, d1);
        end
        wait_idle();
    endtask

    task automatic test_extremes();
        int lat;
        run_conv(16'h0FFF, 16'h0FFF, lat);
        n_checks++;
        if (d0 !== 12'hFFF || d1 !== 12'hFFF) begin
            n_fail++;
            $display("FAIL ones_data: got %h/%h expected fff/fff", d0, d1);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_err: got %b expected 0", err);
        end
        wait_idle();
        run_conv(16'h0000, 16'h0000, lat);
        n_checks++;
        if (d0 !== 12'h000 || d1 !== 12'h000) begin
            n_fail++;
            $display("FAIL zeros_data: got %h/%h expected 000/000", d0, d1);
        end
        n_checks++;
        if (err !== 1'b0 || lat != 100) begin
            n_fail++;
            $display("FAIL zeros_err: got err=%b lat=%0d expected 0/100",
                     err, lat);
        end
        wait_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        sd0      = 1'b0;
        sd1      = 1'b0;
        m0       = '0;
        m1       = '0;
        step();
        test_reset();
        test_basic();
        test_err();
        test_waveform();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_extremes();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
